// File: rtl/mem_access_unit.sv
// Purpose: byte/half/word load-store front end for a single-port word RAM, with read-modify-write for sub-word stores.
// Latency: the response pulses 1 (error), 2 (load, word store) or 3 (sub-word store) cycles after acceptance.
// Backpressure: accepts one request at a time (req_ready only in IDLE); the response has no backpressure.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake; req_we, req_size, req_sext, req_addr, req_wdata are request fields
//   resp_valid/rdata/err        one-cycle completion pulse, load result, misaligned/illegal-size flag
//   ram_cs/rw/addr/wdata/rdata  word RAM port; ram_rdata is combinational from ram_addr
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state, state_nx;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       word_q;   // RAM word captured at the end of RD

  logic              accept;
  logic              req_err;
  logic [31:0]       merged;
  logic [31:0]       load_data;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [ADDR_W-1:0] word_addr;

  // Only used for next-state and capture; no output decodes from req_* directly.
  assign accept  = req_valid && (state == IDLE);
  assign req_err = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      word_q  <= 32'h0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        sext_q  <= req_sext;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      if (state == RD) begin
        word_q <= ram_rdata;
      end
    end
  end

  // Sub-word store: replace the addressed lane(s) of the captured word.
  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = word_q;
    endcase
  end

  // Load: right-align the selected lane(s), then zero/sign extend.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = word_q[7:0];
      2'd1:    byte_sel = word_q[15:8];
      2'd2:    byte_sel = word_q[23:16];
      default: byte_sel = word_q[31:24];
    endcase
    half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (size_q)
      2'b00:   load_data = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_data = word_q;
    endcase
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    ram_cs     = 1'b0;
    ram_rw     = 1'b1;
    ram_addr   = '0;
    ram_wdata  = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)              state_nx = RESP;
          else if (!req_we)         state_nx = RD;
          else if (req_size == 2'b10) state_nx = WR;
          else                      state_nx = RD;   // sub-word store reads first
        end
      end
      RD: begin
        ram_cs   = 1'b1;
        ram_addr = word_addr;
        state_nx = we_q ? WR : RESP;
      end
      WR: begin
        ram_cs    = 1'b1;
        ram_rw    = 1'b0;
        ram_addr  = word_addr;
        ram_wdata = (size_q == 2'b10) ? wdata_q : merged;
        state_nx  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? 32'h0 : load_data;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
